// File: rtl/fc_pkg.sv
// Shared types and constants for the fully-connected result write-back path.
//   fc_wb_state_t : write-back engine state encoding
//   FC_ADDR_W     : bus byte-address width
//   FC_WORD_BYTES : bytes per result word on the bus
//   FC_MAX_BURST  : largest burst a 4-bit awlen can describe
//   fc_burst_len  : awlen (beats-1) for the burst that starts with `remaining` words left
package fc_pkg;

  localparam int unsigned FC_ADDR_W     = 28;
  localparam int unsigned FC_WORD_BYTES = 4;
  localparam int unsigned FC_MAX_BURST  = 16;
  localparam int unsigned FC_LEN_W      = 4;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_ADDR = 2'd1,
    WB_DATA = 2'd2,
    WB_DONE = 2'd3
  } fc_wb_state_t;

  // Burst length field: min(max_burst, remaining) - 1
  function automatic logic [FC_LEN_W-1:0] fc_burst_len(input int unsigned remaining,
                                                        input int unsigned max_burst);
    int unsigned beats;
    beats = (remaining > max_burst) ? max_burst : remaining;
    return FC_LEN_W'(beats - 1);
  endfunction

endpackage

// File: rtl/fc_wb_buf.sv
// Snapshot register array for the write-back engine.
// Ports:
//   clk_i        : clock
//   capture_i    : copy the whole flattened array into the buffer this edge
//   data_i       : flattened array, word k at [(k+1)*WORD_W-1 : k*WORD_W]
//   idx_i        : word index for the read port
//   rd_word_c_o  : combinational read of word idx_i (0 when idx_i is past the end)
module fc_wb_buf #(
  parameter int unsigned DEPTH  = 100,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned IDX_W  = 7
) (
  input  logic                    clk_i,
  input  logic                    capture_i,
  input  logic [DEPTH*WORD_W-1:0] data_i,
  input  logic [IDX_W-1:0]        idx_i,
  output logic [WORD_W-1:0]       rd_word_c_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Contents are don't-care out of reset, so the array carries no reset.
  always_ff @(posedge clk_i) begin
    if (capture_i) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        mem_q[k] <= data_i[k*WORD_W +: WORD_W];
      end
    end
  end

  // Index reaches DEPTH once the drain is finished; return zero there.
  always_comb begin
    rd_word_c_o = '0;
    if (idx_i <= LAST_IDX) begin
      rd_word_c_o = mem_q[idx_i];
    end
  end

endmodule

// File: rtl/fc_wb_burst.sv
// Result write-back engine: snapshots the batch_size x bias_size result array
// on result_en and drains it as incrementing write bursts (AW then W).
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   result, result_en        : flattened result array and its one-cycle valid strobe
//   init_addr, init_addr_en  : base byte address and its load strobe
//   awaddr/awlen/awvalid/awready/awuser_id/awuser_ap : burst address channel
//   wdata/wstrb/wvalid/wready/wlast                  : burst data channel
//   busy    : engine not idle
//   done    : one-cycle pulse after the final beat is accepted
//   overrun : sticky, result_en arrived while busy (cleared on next accept)
// All outputs except awuser_id are registered.
module fc_wb_burst
  import fc_pkg::*;
#(
  parameter int unsigned batch_size = 10,
  parameter int unsigned bias_size  = 10,
  parameter int unsigned word_len   = 32,
  parameter int unsigned max_burst  = FC_MAX_BURST,
  parameter logic [3:0]  user_id    = 4'h1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [batch_size*bias_size*word_len-1:0]  result,
  input  logic                                      result_en,
  input  logic [FC_ADDR_W-1:0]                      init_addr,
  input  logic                                      init_addr_en,
  output logic [FC_ADDR_W-1:0]                      awaddr,
  output logic [FC_LEN_W-1:0]                       awlen,
  output logic                                      awvalid,
  input  logic                                      awready,
  output logic [3:0]                                awuser_id,
  output logic                                      awuser_ap,
  output logic [word_len-1:0]                       wdata,
  output logic [word_len/8-1:0]                     wstrb,
  output logic                                      wvalid,
  input  logic                                      wready,
  output logic                                      wlast,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      overrun
);

  localparam int unsigned N      = batch_size * bias_size;
  localparam int unsigned IDX_W  = $clog2(N + 1);
  localparam int unsigned STRB_W = word_len / 8;

  fc_wb_state_t state_q, state_d;

  logic [FC_ADDR_W-1:0] base_q, base_d;
  logic [FC_ADDR_W-1:0] work_base_q, work_base_d;
  logic [IDX_W-1:0]     word_idx_q, word_idx_d;
  logic [FC_LEN_W-1:0]  beat_q, beat_d;
  logic [FC_LEN_W-1:0]  len_q, len_d;
  logic                 overrun_q, overrun_d;
  logic                 capture_c;

  logic [FC_ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [FC_LEN_W-1:0]  awlen_q, awlen_d;
  logic                 awvalid_q, awvalid_d;
  logic                 awuser_ap_q, awuser_ap_d;
  logic [word_len-1:0]  wdata_q, wdata_d;
  logic [STRB_W-1:0]    wstrb_q, wstrb_d;
  logic                 wvalid_q, wvalid_d;
  logic                 wlast_q, wlast_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [word_len-1:0]  buf_word_c;
  int unsigned          rem_c;

  // Snapshot array; read index follows the next-state word index so wdata
  // can be registered together with the state.
  fc_wb_buf #(
    .DEPTH  (N),
    .WORD_W (word_len),
    .IDX_W  (IDX_W)
  ) u_buf (
    .clk_i       (clk),
    .capture_i   (capture_c),
    .data_i      (result),
    .idx_i       (word_idx_d),
    .rd_word_c_o (buf_word_c)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, counters and base registers
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    work_base_d = work_base_q;
    word_idx_d  = word_idx_q;
    beat_d      = beat_q;
    len_d       = len_q;
    overrun_d   = overrun_q;
    capture_c   = 1'b0;

    if (init_addr_en) begin
      base_d = init_addr;
    end

    unique case (state_q)
      WB_IDLE: begin
        if (result_en) begin
          capture_c   = 1'b1;
          // A same-cycle init_addr_en wins over the stored base.
          work_base_d = init_addr_en ? init_addr : base_q;
          word_idx_d  = '0;
          beat_d      = '0;
          overrun_d   = 1'b0;
          state_d     = WB_ADDR;
        end
      end
      WB_ADDR: begin
        if (awvalid_q && awready) begin
          len_d   = awlen_q;
          beat_d  = '0;
          state_d = WB_DATA;
        end
      end
      WB_DATA: begin
        if (wvalid_q && wready) begin
          word_idx_d = word_idx_q + IDX_W'(1);
          beat_d     = beat_q + FC_LEN_W'(1);
          if (wlast_q) begin
            state_d = (word_idx_d == IDX_W'(N)) ? WB_DONE : WB_ADDR;
          end
        end
      end
      WB_DONE: begin
        state_d = WB_IDLE;
      end
      default: begin
        state_d = WB_IDLE;
      end
    endcase

    // The buffer is left untouched; only the sticky flag records the strobe.
    if (result_en && (state_q != WB_IDLE)) begin
      overrun_d = 1'b1;
    end
  end

  // Output values for the next cycle, decoded from the next state
  always_comb begin
    awaddr_d    = '0;
    awlen_d     = '0;
    awvalid_d   = 1'b0;
    awuser_ap_d = 1'b0;
    wdata_d     = '0;
    wstrb_d     = '0;
    wvalid_d    = 1'b0;
    wlast_d     = 1'b0;
    busy_d      = (state_d != WB_IDLE);
    done_d      = (state_d == WB_DONE);
    rem_c       = N - 32'(word_idx_d);

    if (state_d == WB_ADDR) begin
      awvalid_d   = 1'b1;
      // Byte address wraps within the 28-bit space.
      awaddr_d    = work_base_d + FC_ADDR_W'(32'(word_idx_d) * FC_WORD_BYTES);
      awlen_d     = fc_burst_len(rem_c, max_burst);
      awuser_ap_d = (rem_c <= max_burst);
    end

    if (state_d == WB_DATA) begin
      wvalid_d = 1'b1;
      wstrb_d  = '1;
      wdata_d  = buf_word_c;
      wlast_d  = (beat_d == len_d);
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q      <= '0;
      work_base_q <= '0;
      word_idx_q  <= '0;
      beat_q      <= '0;
      len_q       <= '0;
      overrun_q   <= 1'b0;
      awaddr_q    <= '0;
      awlen_q     <= '0;
      awvalid_q   <= 1'b0;
      awuser_ap_q <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wvalid_q    <= 1'b0;
      wlast_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      base_q      <= base_d;
      work_base_q <= work_base_d;
      word_idx_q  <= word_idx_d;
      beat_q      <= beat_d;
      len_q       <= len_d;
      overrun_q   <= overrun_d;
      awaddr_q    <= awaddr_d;
      awlen_q     <= awlen_d;
      awvalid_q   <= awvalid_d;
      awuser_ap_q <= awuser_ap_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      wvalid_q    <= wvalid_d;
      wlast_q     <= wlast_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign awaddr    = awaddr_q;
  assign awlen     = awlen_q;
  assign awvalid   = awvalid_q;
  assign awuser_id = user_id;
  assign awuser_ap = awuser_ap_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign wvalid    = wvalid_q;
  assign wlast     = wlast_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_fc_wb_burst.sv
// Bench for fc_wb_burst: a scoreboard of expected bursts and beats is filled
// when a result array is launched and drained as the bus handshakes occur.
module tb_fc_wb_burst;

  localparam int unsigned BATCH  = 10;
  localparam int unsigned BIAS   = 10;
  localparam int unsigned WL     = 32;
  localparam int unsigned MB     = 16;
  localparam int unsigned N      = BATCH * BIAS;
  localparam int unsigned NB     = (N + MB - 1) / MB;
  // result_en-to-done latency counted inclusively of both the strobe cycle and the done cycle
  localparam int unsigned LAT    = N + NB + 2;
  localparam int          BUDGET = 2000;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*WL-1:0]   result;
  logic              result_en;
  logic [27:0]       init_addr;
  logic              init_addr_en;
  logic [27:0]       awaddr;
  logic [3:0]        awlen;
  logic              awvalid;
  logic              awready;
  logic [3:0]        awuser_id;
  logic              awuser_ap;
  logic [WL-1:0]     wdata;
  logic [WL/8-1:0]   wstrb;
  logic              wvalid;
  logic              wready;
  logic              wlast;
  logic              busy;
  logic              done;
  logic              overrun;

  typedef struct packed {
    logic [27:0] addr;
    logic [3:0]  len;
    logic        ap;
  } aw_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } w_t;

  aw_t         aw_q[$];
  w_t          w_q[$];
  logic [27:0] aw_seen[$];
  logic [27:0] base_m;
  int          total = 0;
  int          bad = 0;
  int          done_cnt;
  int          beats;

  always #5 clk = ~clk;

  fc_wb_burst dut (
    .clk          (clk),
    .rst          (rst),
    .result       (result),
    .result_en    (result_en),
    .init_addr    (init_addr),
    .init_addr_en (init_addr_en),
    .awaddr       (awaddr),
    .awlen        (awlen),
    .awvalid      (awvalid),
    .awready      (awready),
    .awuser_id    (awuser_id),
    .awuser_ap    (awuser_ap),
    .wdata        (wdata),
    .wstrb        (wstrb),
    .wvalid       (wvalid),
    .wready       (wready),
    .wlast        (wlast),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun)
  );

  function automatic logic [N*WL-1:0] make_result(input logic [31:0] seed);
    logic [N*WL-1:0] r;
    for (int k = 0; k < N; k++) r[k*WL +: WL] = seed + 32'(k);
    return r;
  endfunction

  // Expected bursts and beats for one full drain
  task automatic push_expect(input logic [27:0] base, input logic [31:0] seed);
    aw_t a;
    w_t  w;
    for (int b = 0; b < NB; b++) begin
      int first;
      int cnt;
      first  = b * MB;
      cnt    = (N - first > MB) ? MB : N - first;
      a.addr = base + 28'(first * 4);
      a.len  = 4'(cnt - 1);
      a.ap   = (b == NB - 1);
      aw_q.push_back(a);
    end
    for (int k = 0; k < N; k++) begin
      w.data = seed + 32'(k);
      w.last = ((k % MB) == MB - 1) || (k == N - 1);
      w_q.push_back(w);
    end
  endtask

  task automatic start(input logic [31:0] seed, input bit load, input logic [27:0] addr);
    @(posedge clk); #1;
    result       = make_result(seed);
    result_en    = 1'b1;
    init_addr    = addr;
    init_addr_en = load;
    if (load) base_m = addr;
    push_expect(base_m, seed);
  endtask

  // Runs the bus side until done (or stop_beat beats), checking every handshake.
  task automatic drain(input int aw_stall, input bit w_tog, input int ovr_beat,
                       input int stop_beat, input bit chk_lat);
    int  cyc;
    int  stall;
    bit  ovr_fired;
    bit  p_aw_stall;
    bit  p_w_stall;
    aw_t pa;
    w_t  pw;
    aw_t ea;
    w_t  ew;
    cyc = 0; stall = 0; ovr_fired = 0; p_aw_stall = 0; p_w_stall = 0;
    pa = '0; pw = '0;
    done_cnt = 0; beats = 0;
    aw_seen.delete();
    @(posedge clk); #1;
    result_en    = 1'b0;
    init_addr_en = 1'b0;
    awready      = (aw_stall == 0);
    wready       = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        total++;
        if (awvalid !== 1'b1) begin
          bad++; $display("FAIL aw_first_cycle: awvalid=%b required 1", awvalid);
        end
      end
      total++;
      if ((awvalid & wvalid) !== 1'b0) begin
        bad++; $display("FAIL aw_w_overlap: cycle %0d awvalid=%b wvalid=%b required not both", cyc, awvalid, wvalid);
      end
      total++;
      if (wstrb !== (wvalid ? 4'hF : 4'h0)) begin
        bad++; $display("FAIL wstrb: got %h with wvalid=%b", wstrb, wvalid);
      end
      if (p_aw_stall) begin
        total++;
        if ({awvalid, awaddr, awlen, awuser_ap} !== {1'b1, pa}) begin
          bad++; $display("FAIL aw_hold: got v=%b addr=%h len=%0d required v=1 addr=%h len=%0d", awvalid, awaddr, awlen, pa.addr, pa.len);
        end
      end
      if (p_w_stall) begin
        total++;
        if ({wvalid, wdata, wlast} !== {1'b1, pw}) begin
          bad++; $display("FAIL w_hold: got v=%b data=%h last=%b required v=1 data=%h last=%b", wvalid, wdata, wlast, pw.data, pw.last);
        end
      end
      if (awvalid && awready) begin
        aw_seen.push_back(awaddr);
        stall = 0;
        total++;
        if (aw_q.size() == 0) begin
          bad++; $display("FAIL aw_extra: unexpected burst addr=%h", awaddr);
        end else begin
          ea = aw_q.pop_front();
          if ({awaddr, awlen, awuser_ap} !== ea) begin
            bad++; $display("FAIL aw_burst: got addr=%h len=%0d ap=%b required addr=%h len=%0d ap=%b", awaddr, awlen, awuser_ap, ea.addr, ea.len, ea.ap);
          end
        end
      end else if (awvalid) begin
        stall++;
      end
      if (wvalid && wready) begin
        beats++;
        total++;
        if (w_q.size() == 0) begin
          bad++; $display("FAIL w_extra: unexpected beat data=%h", wdata);
        end else begin
          ew = w_q.pop_front();
          if ({wdata, wlast} !== ew) begin
            bad++; $display("FAIL w_beat: beat %0d got data=%h last=%b required data=%h last=%b", beats, wdata, wlast, ew.data, ew.last);
          end
        end
      end
      if (done) begin
        done_cnt++;
        total++;
        if (busy !== 1'b1) begin
          bad++; $display("FAIL busy_at_done: got %b required 1", busy);
        end
        if (chk_lat) begin
          total++;
          if (cyc + 1 != LAT) begin
            bad++; $display("FAIL latency: got %0d required %0d", cyc + 1, LAT);
          end
        end
      end
      p_aw_stall = awvalid && !awready;
      pa         = {awaddr, awlen, awuser_ap};
      p_w_stall  = wvalid && !wready;
      pw         = {wdata, wlast};
      if (done_cnt > 0) break;
      if (stop_beat >= 0 && beats == stop_beat) break;
      if (cyc >= BUDGET) begin
        total++; bad++;
        $display("FAIL drain_timeout: no done after %0d cycles", cyc);
        break;
      end
      @(posedge clk); #1;
      result_en = 1'b0;
      if (ovr_beat >= 0 && !ovr_fired && beats >= ovr_beat) begin
        result    = make_result(32'h5500_0000);
        result_en = 1'b1;
        ovr_fired = 1'b1;
      end
      awready = (stall >= aw_stall);
      wready  = w_tog ? ~wready : 1'b1;
    end
  endtask

  task automatic post_done();
    @(posedge clk); #1;
    @(negedge clk);
    if (done) done_cnt++;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL busy_after_done: got %b required 0", busy);
    end
    total++;
    if (done_cnt != 1) begin
      bad++; $display("FAIL done_count: got %0d required 1", done_cnt);
    end
    total++;
    if (aw_q.size() != 0 || w_q.size() != 0) begin
      bad++; $display("FAIL leftover: bursts=%0d beats=%0d required 0 0", aw_q.size(), w_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({awaddr, awlen, awvalid, awuser_ap, wdata, wstrb, wvalid, wlast, busy, done, overrun} !== '0) begin
      bad++; $display("FAIL reset_outputs: awaddr=%h awlen=%h wdata=%h flags=%b required all 0", awaddr, awlen, wdata,
                      {awvalid, awuser_ap, wvalid, wlast, busy, done, overrun});
    end
    total++;
    if (awuser_id !== 4'h1) begin
      bad++; $display("FAIL awuser_id: got %h required 1", awuser_id);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    start(32'hA000_0000, 1'b1, 28'h0001000);
    drain(0, 1'b0, -1, -1, 1'b1);
    post_done();
    total++;
    if (aw_seen.size() != 7 || beats != 100) begin
      bad++; $display("FAIL basic_counts: bursts=%0d beats=%0d required 7 100", aw_seen.size(), beats);
    end else begin
      total++;
      if (aw_seen[6] !== 28'h0001180) begin
        bad++; $display("FAIL basic_last_addr: got %h required 0001180", aw_seen[6]);
      end
    end
  endtask

  task automatic test_backpressure();
    start(32'hA000_0000, 1'b0, 28'h0);
    drain(5, 1'b1, -1, -1, 1'b0);
    post_done();
    total++;
    if (beats != 100) begin
      bad++; $display("FAIL bp_beats: got %0d required 100", beats);
    end
  endtask

  task automatic test_overrun();
    start(32'hA000_0000, 1'b0, 28'h0);
    drain(0, 1'b0, 30, -1, 1'b1);
    total++;
    if (overrun !== 1'b1) begin
      bad++; $display("FAIL overrun_set: got %b required 1", overrun);
    end
    post_done();
    start(32'hB000_0000, 1'b0, 28'h0);
    drain(0, 1'b0, -1, -1, 1'b1);
    total++;
    if (overrun !== 1'b0) begin
      bad++; $display("FAIL overrun_clear: got %b required 0", overrun);
    end
    post_done();
  endtask

  task automatic test_wrap();
    start(32'hC000_0000, 1'b1, 28'hFFFFFC0);
    drain(0, 1'b0, -1, -1, 1'b1);
    post_done();
    total++;
    if (aw_seen.size() < 3) begin
      bad++; $display("FAIL wrap_bursts: got %0d required 7", aw_seen.size());
    end else if (aw_seen[1] !== 28'h0000000 || aw_seen[2] !== 28'h0000040) begin
      bad++; $display("FAIL wrap_addr: got %h %h required 0000000 0000040", aw_seen[1], aw_seen[2]);
    end
  endtask

  task automatic test_reset_mid();
    start(32'h1234_0000, 1'b1, 28'h0004000);
    drain(0, 1'b0, -1, 20, 1'b0);
    #1 rst = 1'b1;
    #1;
    total++;
    if ({awaddr, awlen, awvalid, awuser_ap, wdata, wstrb, wvalid, wlast, busy, done, overrun} !== '0) begin
      bad++; $display("FAIL async_reset: awaddr=%h wdata=%h flags=%b required all 0", awaddr, wdata,
                      {awvalid, awuser_ap, wvalid, wlast, busy, done, overrun});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL reset_hold: done=%b busy=%b required 0 0", done, busy);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    aw_q.delete();
    w_q.delete();
    base_m = 28'h0;
    start(32'hD000_0000, 1'b1, 28'h0002000);
    drain(0, 1'b0, -1, -1, 1'b1);
    post_done();
    total++;
    if (aw_seen.size() != 7 || aw_seen[0] !== 28'h0002000) begin
      bad++; $display("FAIL post_reset_drain: bursts=%0d required 7 starting at 0002000", aw_seen.size());
    end
  endtask

  task automatic test_simul_load();
    start(32'hE000_0000, 1'b1, 28'h0003000);
    drain(0, 1'b0, -1, -1, 1'b1);
    post_done();
    total++;
    if (aw_seen.size() == 0 || aw_seen[0] !== 28'h0003000) begin
      bad++; $display("FAIL simul_load: first awaddr missing or not 0003000");
    end
  endtask

  initial begin
    rst          = 1'b1;
    result       = '0;
    result_en    = 1'b0;
    init_addr    = '0;
    init_addr_en = 1'b0;
    awready      = 1'b0;
    wready       = 1'b0;
    base_m       = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_overrun();
    test_wrap();
    test_reset_mid();
    test_simul_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
